// File: rtl/mvu_wr_buffer.sv
// mvu_wr_buffer: elastic FIFO between the data transposer write stream and a stallable MVU bank port.
// Optional write statistics counter enabled by defining MVU_WR_BUFFER_STATS_EN.
module mvu_wr_buffer #(
    parameter int MVU_ADDR_LEN = 15,
    parameter int MVU_DATA_LEN = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_wr_en,
    input  logic [MVU_ADDR_LEN-1:0] in_wr_addr,
    input  logic [MVU_DATA_LEN-1:0] in_wr_word,
    output logic                    in_afull,
    output logic                    in_overflow,
    output logic                    ram_req,
    output logic [MVU_ADDR_LEN-1:0] ram_addr,
    output logic [MVU_DATA_LEN-1:0] ram_word,
    input  logic                    ram_gnt,
    output logic                    empty,
    output logic [31:0]             wr_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = MVU_ADDR_LEN + MVU_DATA_LEN;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(AFULL_THRESH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr, rd_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [EW-1:0] head, head_nxt, in_entry;
    logic          full, pop, push, ovf;

    assign ram_req               = cnt != '0;
    assign empty                 = cnt == '0;
    assign in_afull              = cnt >= THR_CNT;
    assign in_overflow           = ovf;
    assign {ram_addr, ram_word}  = head;

    // head register mirrors mem[rd]; when the pushed entry becomes head it bypasses the array
    always_comb begin
        in_entry = {in_wr_addr, in_wr_word};
        full     = cnt == FULL_CNT;
        pop      = ram_req && ram_gnt;
        push     = in_wr_en && (!full || pop);
        rd_nxt   = pop ? rd + 1'b1 : rd;
        cnt_nxt  = (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
        head_nxt = (cnt_nxt == '0) ? head : (push && wr == rd_nxt) ? in_entry : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            head <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            head <= '0;
            ovf  <= 1'b0;
        end else begin
            rd   <= rd_nxt;
            wr   <= push ? wr + 1'b1 : wr;
            cnt  <= cnt_nxt;
            head <= head_nxt;
            ovf  <= ovf | (in_wr_en && full && !pop);
        end
    end

`ifdef MVU_WR_BUFFER_STATS_EN
    logic [31:0] stat;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat <= '0;
        else if (clr)
            stat <= '0;
        else if (pop && stat != 32'hFFFF_FFFF)
            stat <= stat + 32'd1;
    end
    assign wr_count = stat;
`else
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_mvu_wr_buffer.sv
// tb_mvu_wr_buffer: table-driven check of mvu_wr_buffer plus hand sequences for clr, throughput and reset.
module tb_mvu_wr_buffer;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_wr_en = 1'b0, ram_gnt = 1'b0;
    logic [14:0] in_wr_addr = '0;
    logic [63:0] in_wr_word = '0;
    logic        in_afull, in_overflow, ram_req, empty;
    logic [14:0] ram_addr;
    logic [63:0] ram_word;
    logic [31:0] wr_count;
    int total = 0, bad = 0;

`ifdef MVU_WR_BUFFER_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    mvu_wr_buffer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_word(in_wr_word),
        .in_afull(in_afull), .in_overflow(in_overflow),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_word(ram_word), .ram_gnt(ram_gnt),
        .empty(empty), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en; logic [14:0] a; logic [63:0] w; logic gnt; logic cl;
        logic req; logic [14:0] ea; logic [63:0] ew; logic emp; logic af; logic ov;
    } vec_t;
    vec_t v[$];

    function automatic vec_t mk(input logic en, input int a, input logic [63:0] w, input logic gnt,
                                input logic cl, input logic req, input int ea, input logic [63:0] ew,
                                input logic emp, input logic af, input logic ov);
        vec_t r;
        r.en = en; r.a = 15'(a); r.w = w; r.gnt = gnt; r.cl = cl;
        r.req = req; r.ea = 15'(ea); r.ew = ew; r.emp = emp; r.af = af; r.ov = ov;
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic en, input int a, input logic [63:0] w, input logic gnt, input logic cl);
        in_wr_en = en; in_wr_addr = 15'(a); in_wr_word = w; ram_gnt = gnt; clr = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string n);
        chk({n, " req"}, 64'(ram_req), 64'd0);
        chk({n, " addr"}, 64'(ram_addr), 64'd0);
        chk({n, " word"}, ram_word, 64'd0);
        chk({n, " afull"}, 64'(in_afull), 64'd0);
        chk({n, " ovf"}, 64'(in_overflow), 64'd0);
        chk({n, " empty"}, 64'(empty), 64'd1);
        chk({n, " cnt"}, 64'(wr_count), 64'd0);
    endtask

    initial begin
        v.push_back(mk(1, 'h5, 64'hDEAD_BEEF_0000_0001, 1, 0, 1, 'h5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 'h5, 64'hDEAD_BEEF_0000_0001, 1, 0, 0));
        for (int k = 1; k <= 8; k++)
            v.push_back(mk(1, 'h10 + k - 1, 64'(32'h1000 + k - 1), 0, 0, 1, 'h10, 64'h1000, 0, k >= 6, 0));
        v.push_back(mk(1, 'h18, 64'h1008, 1, 0, 1, 'h11, 64'h1001, 0, 1, 0));
        v.push_back(mk(1, 'h7FF, 64'hBAD, 0, 0, 1, 'h11, 64'h1001, 0, 1, 1));
        for (int j = 0; j < 8; j++)
            v.push_back(mk(0, 0, 0, 1, 0, j < 7, j < 7 ? 'h12 + j : 'h18,
                           64'(j < 7 ? 32'h1002 + j : 32'h1008), j == 7, j <= 1, 1));

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].en, int'(v[i].a), v[i].w, v[i].gnt, v[i].cl);
            step();
            chk($sformatf("r%0d req", i), 64'(ram_req), 64'(v[i].req));
            chk($sformatf("r%0d addr", i), 64'(ram_addr), 64'(v[i].ea));
            chk($sformatf("r%0d word", i), ram_word, v[i].ew);
            chk($sformatf("r%0d empty", i), 64'(empty), 64'(v[i].emp));
            chk($sformatf("r%0d afull", i), 64'(in_afull), 64'(v[i].af));
            chk($sformatf("r%0d ovf", i), 64'(in_overflow), 64'(v[i].ov));
        end
        chk("drain cnt", 64'(wr_count), 64'(10 * ST));
        drive(0, 0, 0, 0, 1);
        step();
        chk_reset("clr ovf");

        // full-rate streaming with grant held high
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h40 + i, 64'(32'h4000 + i), 1, 0);
            step();
            chk($sformatf("tp%0d req", i), 64'(ram_req), 64'd1);
            chk($sformatf("tp%0d addr", i), 64'(ram_addr), 64'('h40 + i));
            chk($sformatf("tp%0d afull", i), 64'(in_afull), 64'd0);
        end
        drive(0, 0, 0, 1, 0);
        step();
        chk("tp empty", 64'(empty), 64'd1);
        chk("tp cnt", 64'(wr_count), 64'(4 * ST));

        // clr coincident with a push, three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h50 + i, 64'(i), 0, 0);
            step();
        end
        chk("pre-clr empty", 64'(empty), 64'd0);
        drive(1, 'h33, 64'h33, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk_reset("clr push");
        step();
        chk("clr push discarded", 64'(ram_req), 64'd0);

        // asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h60 + i, 64'(32'h6000 + i), 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        step();
        chk("mid addr", 64'(ram_addr), 64'h61);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post rst%0d req", i), 64'(ram_req), 64'd0);
            chk($sformatf("post rst%0d addr", i), 64'(ram_addr), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mvu_wr_buffer.md
# mvu_wr_buffer

Elastic write buffer directly downstream of `data_transposer`. It accepts the transposer's bit-plane write stream (`mvu_wr_en`/`mvu_wr_addr`/`mvu_wr_word`) and queues it in a small FIFO. It replays the queued writes into an MVU data-bank write port that can stall through a request/grant handshake. It also gives the transposer driver an almost-full throttle and a sticky overflow flag, so bursts are never silently lost.

## Interface
- `MVU_ADDR_LEN`, 15, width of the MVU bank word address
- `MVU_DATA_LEN`, 64, width of one bit-plane word
- `DEPTH`, 8, FIFO entries; power of two, 2 to 64
- `AFULL_THRESH`, 6, occupancy at or above which `in_afull` asserts; 1 ≤ value ≤ `DEPTH`

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous clear: empty the FIFO, clear the flags and the statistics
- `in_wr_en`  in  1  push strobe, from transposer `mvu_wr_en`
- `in_wr_addr`  in  `MVU_ADDR_LEN`  push address
- `in_wr_word`  in  `MVU_DATA_LEN`  push data
- `in_afull`  out  1  occupancy ≥ `AFULL_THRESH`
- `in_overflow`  out  1  sticky flag: a push was dropped
- `ram_req`  out  1  head entry valid
- `ram_addr`  out  `MVU_ADDR_LEN`  head address
- `ram_word`  out  `MVU_DATA_LEN`  head data
- `ram_gnt`  in  1  MVU port accepts the head this cycle
- `empty`  out  1  FIFO empty; the driver uses it to detect a drained buffer before it deasserts the job
- `wr_count`  out  32  number of accepted RAM writes (see Configuration)

## Operation
- Circular buffer with read and write pointers of `$clog2(DEPTH)` bits. The occupancy counter is `$clog2(DEPTH)+1` bits.
- Push: `in_wr_en` = 1 and the FIFO is not full, or the FIFO is full and a pop happens in the same cycle. The entry `{addr, word}` is written at the write pointer and the write pointer increments, wrapping modulo `DEPTH`.
- Pop: `ram_req && ram_gnt`. The read pointer increments, wrapping modulo `DEPTH`.
- The read path is show-ahead. `ram_addr`/`ram_word` always present the head entry. When `ram_req` = 0 they hold the last popped entry, or 0 after reset/`clr`.
- Occupancy changes by +1 on push only, −1 on pop only, and is unchanged on push and pop together.
- Overflow: `in_wr_en` while full with no pop. The incoming word is dropped and `in_overflow` is set. It stays set until `clr` or reset.
- `clr` takes priority over push and pop in the same cycle. Pointers, occupancy, `in_overflow` and `wr_count` all go to 0, and the push in that cycle is discarded.
- Entries are written to the RAM strictly in arrival order; the block never reorders or merges them.

## Timing
- All outputs are registered or decoded from registers. Reset values: `ram_req`=0, `ram_addr`=0, `ram_word`=0, `in_afull`=0, `in_overflow`=0, `empty`=1, `wr_count`=0.
- Latency: a push at edge N gives `ram_req`=1 with that entry after edge N, if the FIFO was empty. Minimum latency is 1 cycle.
- With `ram_gnt` held at 1, throughput is 1 word per cycle and occupancy stays at 0 or 1.
- `ram_req` does not depend combinationally on `ram_gnt`. `ram_gnt` with `ram_req`=0 is ignored.
- `in_afull` updates one cycle after the occupancy change. The driver must stop pushing within `DEPTH − AFULL_THRESH` cycles of seeing it.
- Reset asserted in the middle of a burst loses the queued entries and the outputs go to their reset values immediately, asynchronously.

## Configuration
- `MVU_WR_BUFFER_STATS_EN` defined: `wr_count` increments by 1 on every pop. It saturates at 0xFFFF_FFFF and is cleared by `clr` or reset.
- Not defined: the counter is not implemented and `wr_count` is tied to 0. All other behaviour is identical.

## Test plan
- Single push, addr 0x0005 / word 0xDEAD_BEEF_0000_0001, with `ram_gnt`=1 → `ram_req` high for exactly one cycle, one cycle after the push, carrying that addr/word; `empty` then returns to 1.
- 8 back-to-back pushes with `ram_gnt`=0, then `ram_gnt`=1 → `in_afull` = 1 after the 6th push. After `ram_gnt` goes high, the 8 words drain in order on 8 consecutive cycles, and `wr_count` = 8 with the STATS macro defined.
- 9th push while full and no grant → that word is never seen on `ram_*`, `in_overflow` = 1 and stays 1 after the drain, and `clr` returns it to 0.
- Push and grant in the same cycle while full → the push is accepted, occupancy stays 8 and `in_overflow` stays 0.
- `clr` together with a push, with 3 entries queued → next cycle `empty` = 1, `ram_req` = 0 and `wr_count` = 0.
- `rst_n` dropped mid-drain with 4 entries queued → all outputs are at reset values before the next clock edge, and after release no stale writes appear.
